// File: rtl/rv32i_memoryaccess.sv
// rtl/rv32i_memoryaccess.sv - RV32I memory-access stage driving a pipelined Wishbone data bus
module rv32i_memoryaccess #(
  parameter int ACK_TIMEOUT = 1023,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [31:0]           i_y,
  input  logic [31:0]           i_rs2,
  input  logic [2:0]            i_funct3,
  input  logic                  i_load,
  input  logic                  i_store,
  input  logic                  i_wr_rd,
  input  logic [4:0]            i_rd_addr,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [31:0]           i_wb_data,
  output logic [4:0]            o_rd_addr,
  output logic [31:0]           o_rd,
  output logic                  o_wr_rd,
  output logic                  o_ce,
  output logic                  o_stall_from_mem,
  output logic                  o_misaligned,
  output logic                  o_bus_err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] timer;
  logic          flushed;
  logic          load_q;
  logic          wr_rd_q;
  logic [1:0]    byte_off;
  logic [2:0]    funct3_q;
  logic [4:0]    rd_addr_q;
  logic [31:0]   y_q;
  logic [31:0]   pend_rd;

  logic          accept;
  logic          is_mem;
  logic          misaligned;
  logic          ack_now;
  logic          timed_out;
  logic [3:0]    st_sel;
  logic [31:0]   st_data;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_ext;
  logic [31:0]   result;

  assign accept    = i_ce & ~i_stall & ~i_flush & (state == IDLE);
  assign is_mem    = i_load | i_store;
  assign ack_now   = i_wb_ack & ((state == WAIT) | ((state == REQ) & ~i_wb_stall));
  assign timed_out = ((state == REQ) | (state == WAIT)) & (timer == CW'(ACK_TIMEOUT));
  assign result    = load_q ? load_ext : y_q;

  always_comb begin
    misaligned = 1'b0;
    st_sel     = 4'b1111;
    st_data    = i_rs2;
    case (i_funct3[1:0])
      2'b00: begin
        st_sel  = 4'b0001 << i_y[1:0];
        st_data = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        misaligned = i_y[0];
        st_sel     = i_y[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{i_rs2[15:0]}};
      end
      default: misaligned = |i_y[1:0];
    endcase
    if (i_load) st_sel = 4'b1111;
  end

  // funct3[2] marks the unsigned variants (LBU/LHU)
  always_comb begin
    lane_b = i_wb_data[{byte_off, 3'b000} +: 8];
    lane_h = byte_off[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~funct3_q[2] & lane_h[15]}}, lane_h};
      default: load_ext = i_wb_data;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      timer            <= '0;
      flushed          <= 1'b0;
      load_q           <= 1'b0;
      wr_rd_q          <= 1'b0;
      byte_off         <= 2'b00;
      funct3_q         <= 3'b000;
      rd_addr_q        <= 5'd0;
      y_q              <= 32'd0;
      pend_rd          <= 32'd0;
      o_wb_cyc         <= 1'b0;
      o_wb_stb         <= 1'b0;
      o_wb_we          <= 1'b0;
      o_wb_addr        <= '0;
      o_wb_data        <= 32'd0;
      o_wb_sel         <= 4'b0000;
      o_rd_addr        <= 5'd0;
      o_rd             <= 32'd0;
      o_wr_rd          <= 1'b0;
      o_ce             <= 1'b0;
      o_stall_from_mem <= 1'b0;
      o_misaligned     <= 1'b0;
      o_bus_err        <= 1'b0;
    end else begin
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_flush) begin
            o_ce    <= 1'b0;
            o_wr_rd <= 1'b0;
          end else if (accept && !is_mem) begin
            o_ce      <= 1'b1;
            o_rd      <= i_y;
            o_rd_addr <= i_rd_addr;
            o_wr_rd   <= i_wr_rd;
          end else if (accept && misaligned) begin
            o_ce         <= 1'b0;
            o_wr_rd      <= 1'b0;
            o_misaligned <= 1'b1;
          end else if (accept) begin
            o_ce             <= 1'b0;
            o_wr_rd          <= 1'b0;
            o_wb_cyc         <= 1'b1;
            o_wb_stb         <= 1'b1;
            o_wb_we          <= i_store;
            o_wb_addr        <= ADDR_WIDTH'({i_y[31:2], 2'b00});
            o_wb_data        <= st_data;
            o_wb_sel         <= st_sel;
            o_stall_from_mem <= 1'b1;
            load_q           <= i_load;
            wr_rd_q          <= i_wr_rd;
            byte_off         <= i_y[1:0];
            funct3_q         <= i_funct3;
            rd_addr_q        <= i_rd_addr;
            y_q              <= i_y;
            timer            <= '0;
            flushed          <= 1'b0;
            state            <= REQ;
          end else if (!i_stall) begin
            o_ce    <= 1'b0;
            o_wr_rd <= 1'b0;
          end
        end
        REQ, WAIT: begin
          if (i_flush) flushed <= 1'b1;
          if (ack_now) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            timer    <= '0;
            if (flushed || i_flush) begin
              o_ce             <= 1'b0;
              o_wr_rd          <= 1'b0;
              o_stall_from_mem <= 1'b0;
              flushed          <= 1'b0;
              state            <= IDLE;
            end else if (i_stall) begin
              // writeback is busy: park the result until it can be taken
              pend_rd <= result;
              state   <= HOLD;
            end else begin
              o_ce             <= 1'b1;
              o_rd             <= result;
              o_rd_addr        <= rd_addr_q;
              o_wr_rd          <= load_q & wr_rd_q;
              o_stall_from_mem <= 1'b0;
              state            <= IDLE;
            end
          end else if (timed_out) begin
            o_wb_cyc         <= 1'b0;
            o_wb_stb         <= 1'b0;
            o_bus_err        <= 1'b1;
            o_ce             <= 1'b0;
            o_wr_rd          <= 1'b0;
            o_stall_from_mem <= 1'b0;
            timer            <= '0;
            flushed          <= 1'b0;
            state            <= IDLE;
          end else begin
            timer <= timer + CW'(1);
            if (state == REQ && !i_wb_stall) begin
              o_wb_stb <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        HOLD: begin
          if (i_flush) begin
            o_ce             <= 1'b0;
            o_wr_rd          <= 1'b0;
            o_stall_from_mem <= 1'b0;
            state            <= IDLE;
          end else if (!i_stall) begin
            o_ce             <= 1'b1;
            o_rd             <= pend_rd;
            o_rd_addr        <= rd_addr_q;
            o_wr_rd          <= load_q & wr_rd_q;
            o_stall_from_mem <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// tb/tb_rv32i_memoryaccess.sv - scoreboard bench for the RV32I memory-access stage
module tb_rv32i_memoryaccess;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ce = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [31:0] i_y = '0, i_rs2 = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_load = 1'b0, i_store = 1'b0, i_wr_rd = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0;
  logic [31:0] i_wb_data = '0;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;
  logic        o_wr_rd, o_ce, o_stall_from_mem, o_misaligned, o_bus_err;

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  addr;
    logic        wr;
    logic        chk_rd;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  rv32i_memoryaccess #(.ACK_TIMEOUT(8), .ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
    .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3), .i_load(i_load), .i_store(i_store),
    .i_wr_rd(i_wr_rd), .i_rd_addr(i_rd_addr),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_data(i_wb_data), .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_wr_rd(o_wr_rd), .o_ce(o_ce),
    .o_stall_from_mem(o_stall_from_mem), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // writeback scoreboard: compare each consumed o_ce beat against the oldest expectation
  always @(negedge i_clk) begin
    if (!i_rst && o_ce && !i_stall) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        check("wb_rd_addr", {27'd0, o_rd_addr}, {27'd0, e.addr});
        check("wb_wr_rd", {31'd0, o_wr_rd}, {31'd0, e.wr});
        if (e.chk_rd) check("wb_rd", o_rd, e.rd);
      end
    end
  end

  task automatic expect_wb(input logic [31:0] rd, input logic [4:0] addr, input logic wr, input logic chk);
    wb_exp_t e;
    e.rd = rd; e.addr = addr; e.wr = wr; e.chk_rd = chk;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] y, input logic [31:0] rs2, input logic [2:0] f3,
                       input logic ld, input logic st, input logic wr, input logic [4:0] rd);
    i_ce = 1'b1; i_y = y; i_rs2 = rs2; i_funct3 = f3;
    i_load = ld; i_store = st; i_wr_rd = wr; i_rd_addr = rd;
    @(posedge i_clk); #1;
    i_ce = 1'b0; i_load = 1'b0; i_store = 1'b0;
  endtask

  // slave model: hold off the strobe for stall_n cycles, then ack ack_wait cycles after acceptance
  task automatic serve(input int stall_n, input int ack_wait, input logic [31:0] rdata, output int stb_cycles);
    stb_cycles = 0;
    for (int c = 0; c < stall_n; c++) begin
      i_wb_stall = 1'b1;
      @(negedge i_clk); if (o_wb_stb) stb_cycles++;
      @(posedge i_clk); #1;
    end
    i_wb_stall = 1'b0;
    if (ack_wait == 0) begin i_wb_ack = 1'b1; i_wb_data = rdata; end
    @(negedge i_clk); if (o_wb_stb) stb_cycles++;
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    if (ack_wait > 0) begin
      repeat (ack_wait - 1) begin @(posedge i_clk); #1; end
      i_wb_ack = 1'b1; i_wb_data = rdata;
      @(posedge i_clk); #1;
      i_wb_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stbs;
    int n;
    int got;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ce", {31'd0, o_ce}, 32'd0);
    check("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("rst_stall", {31'd0, o_stall_from_mem}, 32'd0);
    check("rst_rd", o_rd, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // ALU pass-through
    expect_wb(32'h1234, 5'd5, 1'b1, 1'b1);
    issue(32'h1234, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5);
    #1 check("alu_cyc", {31'd0, o_wb_cyc}, 32'd0);
    @(posedge i_clk); #1;

    // SB with two stall cycles and ack two cycles after acceptance
    expect_wb(32'd0, 5'd7, 1'b0, 1'b0);
    issue(32'h1003, 32'h000000AB, 3'b000, 1'b0, 1'b1, 1'b1, 5'd7);
    #1;
    check("sb_cyc", {31'd0, o_wb_cyc}, 32'd1);
    check("sb_we", {31'd0, o_wb_we}, 32'd1);
    check("sb_addr", o_wb_addr, 32'h1000);
    check("sb_sel", {28'd0, o_wb_sel}, 32'h8);
    check("sb_data", o_wb_data, 32'hABABABAB);
    check("sb_stall_mem", {31'd0, o_stall_from_mem}, 32'd1);
    serve(2, 2, 32'd0, stbs);
    check("sb_stb_cycles", stbs, 32'd3);
    check("sb_cyc_done", {31'd0, o_wb_cyc}, 32'd0);
    check("sb_stall_done", {31'd0, o_stall_from_mem}, 32'd0);
    @(posedge i_clk); #1;

    // SH upper half, SW
    expect_wb(32'd0, 5'd1, 1'b0, 1'b0);
    issue(32'h1002, 32'h0000CDEF, 3'b001, 1'b0, 1'b1, 1'b0, 5'd1);
    #1;
    check("sh_sel", {28'd0, o_wb_sel}, 32'hC);
    check("sh_data", o_wb_data, 32'hCDEFCDEF);
    serve(0, 1, 32'd0, stbs);
    expect_wb(32'd0, 5'd2, 1'b0, 1'b0);
    issue(32'h1008, 32'h13579BDF, 3'b010, 1'b0, 1'b1, 1'b0, 5'd2);
    #1;
    check("sw_sel", {28'd0, o_wb_sel}, 32'hF);
    check("sw_data", o_wb_data, 32'h13579BDF);
    serve(0, 1, 32'd0, stbs);

    // loads with extension
    expect_wb(32'hFFFFFF80, 5'd10, 1'b1, 1'b1);
    issue(32'h2001, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd10);
    #1;
    check("lb_we", {31'd0, o_wb_we}, 32'd0);
    check("lb_sel", {28'd0, o_wb_sel}, 32'hF);
    check("lb_addr", o_wb_addr, 32'h2000);
    serve(0, 1, 32'h00008000, stbs);
    expect_wb(32'h00000080, 5'd11, 1'b1, 1'b1);
    issue(32'h2001, 32'd0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd11);
    serve(1, 2, 32'h00008000, stbs);
    expect_wb(32'h0000BEEF, 5'd12, 1'b1, 1'b1);
    issue(32'h2002, 32'd0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd12);
    serve(0, 0, 32'hBEEF0000, stbs);
    expect_wb(32'hFFFF8001, 5'd13, 1'b1, 1'b1);
    issue(32'h2002, 32'd0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd13);
    serve(0, 1, 32'h80010000, stbs);
    expect_wb(32'h12345678, 5'd14, 1'b1, 1'b1);
    issue(32'h2004, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd14);
    serve(0, 3, 32'h12345678, stbs);
    @(posedge i_clk); #1;

    // misaligned LW and LH
    issue(32'h3002, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd4);
    #1;
    check("mis_lw_pulse", {31'd0, o_misaligned}, 32'd1);
    check("mis_lw_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("mis_lw_ce", {31'd0, o_ce}, 32'd0);
    issue(32'h3001, 32'd0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd4);
    #1 check("mis_lh_pulse", {31'd0, o_misaligned}, 32'd1);
    @(posedge i_clk); #1;
    check("mis_pulse_end", {31'd0, o_misaligned}, 32'd0);

    // timeout: no ack, bus error 8 cycles after strobe acceptance
    issue(32'h4000, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd6);
    i_wb_stall = 1'b0;
    @(posedge i_clk); #1;
    n = 0; got = -1;
    repeat (12) begin
      @(posedge i_clk); n++;
      @(negedge i_clk);
      if (o_bus_err && got < 0) begin
        got = n;
        check("to_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("to_stall", {31'd0, o_stall_from_mem}, 32'd0);
      end
    end
    check("to_cycles", got, 32'd8);
    check("to_pulse_end", {31'd0, o_bus_err}, 32'd0);
    @(posedge i_clk); #1;

    // flush during WAIT: bus completes, result discarded
    issue(32'h2008, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd3);
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("fl_cyc_held0", {31'd0, o_wb_cyc}, 32'd1);
    repeat (2) begin @(posedge i_clk); #1; end
    check("fl_cyc_held1", {31'd0, o_wb_cyc}, 32'd1);
    i_wb_ack = 1'b1; i_wb_data = 32'h55AA55AA;
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    check("fl_cyc_done", {31'd0, o_wb_cyc}, 32'd0);
    check("fl_ce", {31'd0, o_ce}, 32'd0);
    check("fl_stall", {31'd0, o_stall_from_mem}, 32'd0);

    // ce together with flush: dropped
    i_flush = 1'b1;
    issue(32'h9999, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9);
    i_flush = 1'b0;
    #1 check("cefl_ce", {31'd0, o_ce}, 32'd0);

    // ack under downstream stall is parked and presented later
    issue(32'h2004, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd15);
    @(posedge i_clk); #1;
    i_stall = 1'b1; i_wb_ack = 1'b1; i_wb_data = 32'hCAFEF00D;
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    #1;
    check("hold_ce", {31'd0, o_ce}, 32'd0);
    check("hold_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("hold_stall", {31'd0, o_stall_from_mem}, 32'd1);
    @(posedge i_clk); #1;
    check("hold_ce2", {31'd0, o_ce}, 32'd0);
    expect_wb(32'hCAFEF00D, 5'd15, 1'b1, 1'b1);
    i_stall = 1'b0;
    @(posedge i_clk); #1;
    check("hold_release", {31'd0, o_stall_from_mem}, 32'd0);
    @(posedge i_clk); #1;

    // async reset mid-WAIT
    issue(32'h2000, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd8);
    @(posedge i_clk); #1;
    check("arst_pre_cyc", {31'd0, o_wb_cyc}, 32'd1);
    #1 i_rst = 1'b1;
    #1;
    check("arst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("arst_stb", {31'd0, o_wb_stb}, 32'd0);
    check("arst_stall", {31'd0, o_stall_from_mem}, 32'd0);
    check("arst_ce", {31'd0, o_ce}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end

    check("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
